// File: rtl/adder_seq_pkg.sv
// Shared constants and FSM encoding for the chunked adder sequencer.
// Optional subtract mode in adder_sequencer is enabled with ADDER_SEQ_SUB_EN.
package adder_seq_pkg;

   localparam int N_DEF     = 4;
   localparam int WORDS_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter width: enough to hold WORDS itself so the last increment never wraps.
   function automatic int cnt_width(input int words);
      return $clog2(words) + 1;
   endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain N-bit ripple-carry adder; the only arithmetic resource of the sequencer.
module ripple_carry_adder #(
   parameter int W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         c_i,
   output logic [W-1:0] s_o,
   output logic         c_o
);

   always_comb begin : ripple
      logic carry;
      carry = c_i;
      s_o   = '0;
      for (int i = 0; i < W; i++) begin
         s_o[i] = a_i[i] ^ b_i[i] ^ carry;
         carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
      c_o = carry;
   end

endmodule

// File: rtl/adder_sequencer.sv
// Multi-cycle adder: one N-bit chunk per cycle through a shared ripple adder.
// Define ADDER_SEQ_SUB_EN to add the sub port (A - B via inverted B and carry-in 1).
module adder_sequencer
   import adder_seq_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int WORDS = WORDS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*WORDS-1:0]   in1,
   input  logic [N*WORDS-1:0]   in2,
   input  logic                 cin,
`ifdef ADDER_SEQ_SUB_EN
   input  logic                 sub,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N*WORDS-1:0]   sum,
   output logic                 cout,
   output logic                 busy
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; in_ready depends only on state, never on out_ready.

   localparam int W  = N * WORDS;
   localparam int CW = cnt_width(WORDS);

   state_e          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            carry_q, carry_d;
   logic            cout_q, cout_d;
   logic [CW-1:0]   k_q, k_d;

   logic [N-1:0]    a_chunk;
   logic [N-1:0]    b_chunk;
   logic [N-1:0]    add_s;
   logic            add_co;

   // Explicit chunk mux keeps every select in range even when k_q == WORDS.
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (k_q == CW'(i)) begin
            a_chunk = a_q[i*N +: N];
            b_chunk = b_q[i*N +: N];
         end
      end
   end

   ripple_carry_adder #(
      .W (N)
   ) u_rca (
      .a_i (a_chunk),
      .b_i (b_chunk),
      .c_i (carry_q),
      .s_o (add_s),
      .c_o (add_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      k_d     = k_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in1;
`ifdef ADDER_SEQ_SUB_EN
               b_d     = sub ? ~in2 : in2;
               carry_d = sub ? 1'b1 : cin;
`else
               b_d     = in2;
               carry_d = cin;
`endif
               sum_d   = '0;
               cout_d  = 1'b0;
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < WORDS; i++) begin
               if (k_q == CW'(i)) begin
                  sum_d[i*N +: N] = add_s;
               end
            end
            carry_d = add_co;
            k_d     = k_q + CW'(1);
            if (k_q == CW'(WORDS - 1)) begin
               cout_d  = add_co;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Self-checking bench for adder_sequencer (N=4, WORDS=4) against an arithmetic model.
module tb_adder_sequencer;

   localparam int N     = 4;
   localparam int WORDS = 4;
   localparam int W     = N * WORDS;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in1;
   logic [W-1:0]  in2;
   logic          cin;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;
   logic          busy;

   logic [W:0]    exp_q[$];
   int            n_vec;
   int            n_miss;

   adder_sequencer #(
      .N     (N),
      .WORDS (WORDS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .cin       (cin),
`ifdef ADDER_SEQ_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: whole-word unsigned arithmetic, carry out in bit W.
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c, input logic s);
      logic [W-1:0] nb;
      nb = ~b;
      if (s) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
   endfunction

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input int hold, input logic early);
      int         lat;
      logic [W:0] e;
      logic [W-1:0] held;
      @(negedge clk);
      in1       = a;
      in2       = b;
      cin       = c;
      sub       = s;
      in_valid  = 1'b1;
      out_ready = early;
      check_eq("in_ready_idle", in_ready, 1);
      exp_q.push_back(model(a, b, c, s));
      @(posedge clk);
      #1;
      check_eq("busy_run", {in_ready, busy}, 2'b01);
      lat = 0;
      while (!out_valid && lat < 64) begin
         in1      = W'($urandom);
         in2      = W'($urandom);
         cin      = 1'($urandom);
         sub      = 1'($urandom);
         in_valid = 1'($urandom);
         @(posedge clk);
         #1;
         lat++;
      end
      in_valid = 1'b0;
      check_eq("latency", lat, WORDS);
      e = exp_q.pop_front();
      check_eq("result", {cout, sum}, e);
      held = sum;
      if (!early) begin
         for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_sum", sum, held);
            check_eq("hold_flags", {out_valid, in_ready, cout}, {2'b10, e[W]});
         end
         out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      check_eq("back_idle", {out_valid, in_ready, busy}, 3'b010);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         s_en;
      n_vec     = 0;
      n_miss    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in1       = '0;
      in2       = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b0;
`ifdef ADDER_SEQ_SUB_EN
      s_en = 1'b1;
`else
      s_en = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_state", {in_ready, out_valid, busy, cout}, 4'b1000);
      check_eq("reset_sum", sum, 0);
      @(negedge clk);
      rst = 1'b0;

      do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
      do_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, 5, 1'b0);
      do_op(16'hABCD, 16'h5432, 1'b1, 1'b0, 1, 1'b1);

      // Abort two cycles into RUN; reset must clear outputs without a clock edge.
      @(negedge clk);
      in1      = 16'h7777;
      in2      = 16'h8888;
      cin      = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_eq("midrun_rst_flags", {in_ready, out_valid, busy, cout}, 4'b1000);
      check_eq("midrun_rst_sum", sum, 0);
      @(negedge clk);
      rst = 1'b0;
      do_op(16'h0001, 16'h0001, 1'b1, 1'b0, 0, 1'b0);

      if (s_en) begin
         do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
         do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 2, 1'b0);
      end

      for (int t = 0; t < 30; t++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (t % 5 == 0) rb = ~ra;
         do_op(ra, rb, 1'($urandom), 1'($urandom) & s_en,
               $urandom_range(0, 3), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
